// File: rtl/i2c_pkg.sv
// Shared constants for the I2C APB register front end: register offsets,
// CTRL/STATUS bit positions and the transfer-control state encoding.
package i2c_pkg;

  // Byte offsets; paddr[1:0] never takes part in decode
  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_ADDR   = 5'h04;
  localparam logic [4:0] A_CNT    = 5'h08;
  localparam logic [4:0] A_DIV    = 5'h0C;
  localparam logic [4:0] A_TXDATA = 5'h10;
  localparam logic [4:0] A_RXDATA = 5'h14;
  localparam logic [4:0] A_STATUS = 5'h18;

  // CTRL bits
  localparam int C_START = 0;
  localparam int C_TXCLR = 1;
  localparam int C_RXCLR = 2;
  localparam int C_IRQEN = 8;

  // STATUS bits / fields
  localparam int S_BUSY  = 0;
  localparam int S_DONE  = 1;
  localparam int S_TXE   = 2;
  localparam int S_TXF   = 3;
  localparam int S_RXE   = 4;
  localparam int S_RXF   = 5;
  localparam int S_TXOVF = 6;
  localparam int S_RXUDF = 7;
  localparam int S_TXLVL = 8;
  localparam int S_RXLVL = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } xfer_st_e;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock byte FIFO with first-word-fall-through head. Clear wins over
// push/pop; push when full and pop when empty are ignored.
module i2c_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head reads as 0 when empty so data_in is clean out of reset
  assign rdata   = empty ? '0 : mem[rp];

  // Pointers and level; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: contents are only visible while level > 0
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/i2c_apb_regs.sv
// APB register front end for the I2C master: configuration registers,
// START/done handshake, TX/RX byte FIFOs and the done interrupt.
module i2c_apb_regs
  import i2c_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq,
  output logic        i_ready,
  output logic [7:0]  data_addr_rw,
  output logic [7:0]  data_cnt,
  output logic [15:0] div_cnt,
  output logic [7:0]  data_in,
  output logic        i_txff_empty,
  output logic        i_rxff_full,
  input  logic        i_txff_rd,
  input  logic        i_rxff_wr,
  input  logic [7:0]  data_out,
  input  logic        i2c_done
);

  xfer_st_e    state;
  logic        busy, acc, wr, rd, err, wr_ok;
  logic        cfg_wr, start_wr;
  logic [4:0]  a;
  logic        irq_en, done_st, tx_ovf, rx_udf;
  logic        tx_push, tx_clr, tx_empty, tx_full;
  logic        rx_pop, rx_clr, rx_empty, rx_full;
  logic [7:0]  rx_head;
  logic [AW:0] tx_level, rx_level;
  logic [31:0] status;
  logic        unused_ok;

  assign unused_ok = ^{pwdata[31:16], paddr[1:0]};

  assign a        = {paddr[4:2], 2'b00};
  assign acc      = psel & penable;
  assign wr       = acc & pwrite;
  assign rd       = acc & ~pwrite;
  assign busy     = (state == ST_BUSY);
  assign cfg_wr   = wr & ((a == A_ADDR) | (a == A_CNT) | (a == A_DIV));
  assign start_wr = wr & (a == A_CTRL) & pwdata[C_START];
  // Config changes and a second START during a transfer are rejected
  assign err      = busy & (cfg_wr | start_wr);
  assign wr_ok    = wr & ~err;

  assign pready   = 1'b1;
  assign pslverr  = err;
  assign irq      = done_st & irq_en;

  assign tx_push  = wr & (a == A_TXDATA);
  assign tx_clr   = wr_ok & (a == A_CTRL) & pwdata[C_TXCLR];
  assign rx_clr   = wr_ok & (a == A_CTRL) & pwdata[C_RXCLR];
  assign rx_pop   = rd & (a == A_RXDATA);

  assign i_txff_empty = tx_empty;
  assign i_rxff_full  = rx_full;

  // Configuration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en       <= 1'b0;
      data_addr_rw <= '0;
      data_cnt     <= '0;
      div_cnt      <= '0;
    end else if (wr_ok) begin
      case (a)
        A_CTRL: irq_en       <= pwdata[C_IRQEN];
        A_ADDR: data_addr_rw <= pwdata[7:0];
        A_CNT:  data_cnt     <= pwdata[7:0];
        A_DIV:  div_cnt      <= pwdata[15:0];
        default: ;
      endcase
    end
  end

  // Transfer control; i_ready held for the whole transfer since the master
  // only samples it on its SCL tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      i_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_wr) begin
          state   <= ST_BUSY;
          i_ready <= 1'b1;
        end
        ST_BUSY: if (i2c_done) begin
          state   <= ST_IDLE;
          i_ready <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky status bits; a set event beats a same-cycle W1C
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_st <= 1'b0;
      tx_ovf  <= 1'b0;
      rx_udf  <= 1'b0;
    end else begin
      if (wr && a == A_STATUS) begin
        if (pwdata[S_DONE])  done_st <= 1'b0;
        if (pwdata[S_TXOVF]) tx_ovf  <= 1'b0;
        if (pwdata[S_RXUDF]) rx_udf  <= 1'b0;
      end
      if (busy && i2c_done)   done_st <= 1'b1;
      if (tx_push && tx_full) tx_ovf  <= 1'b1;
      if (rx_pop && rx_empty) rx_udf  <= 1'b1;
    end
  end

  i2c_sync_fifo #(.DEPTH(DEPTH), .DW(8)) u_txff (
    .clk(clk), .rst(rst), .push(tx_push), .pop(i_txff_rd), .clr(tx_clr),
    .wdata(pwdata[7:0]), .rdata(data_in), .empty(tx_empty), .full(tx_full),
    .level(tx_level)
  );

  i2c_sync_fifo #(.DEPTH(DEPTH), .DW(8)) u_rxff (
    .clk(clk), .rst(rst), .push(i_rxff_wr), .pop(rx_pop), .clr(rx_clr),
    .wdata(data_out), .rdata(rx_head), .empty(rx_empty), .full(rx_full),
    .level(rx_level)
  );

  // STATUS word assembly
  always_comb begin
    status            = '0;
    status[S_BUSY]    = busy;
    status[S_DONE]    = done_st;
    status[S_TXE]     = tx_empty;
    status[S_TXF]     = tx_full;
    status[S_RXE]     = rx_empty;
    status[S_RXF]     = rx_full;
    status[S_TXOVF]   = tx_ovf;
    status[S_RXUDF]   = rx_udf;
    status[S_TXLVL +: 4] = 4'(tx_level);
    status[S_RXLVL +: 4] = 4'(rx_level);
  end

  // Read mux, live only in the access phase of a read
  always_comb begin
    prdata = '0;
    if (rd) begin
      case (a)
        A_CTRL:   prdata[C_IRQEN] = irq_en;
        A_ADDR:   prdata[7:0]     = data_addr_rw;
        A_CNT:    prdata[7:0]     = data_cnt;
        A_DIV:    prdata[15:0]    = div_cnt;
        A_RXDATA: prdata[7:0]     = rx_head;
        A_STATUS: prdata          = status;
        default:  prdata          = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Directed bench for i2c_apb_regs: APB register access, transfer handshake,
// FIFO boundaries and asynchronous reset.
module tb_i2c_apb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, irq, i_ready;
  logic [7:0]  data_addr_rw, data_cnt, data_in, data_out;
  logic [15:0] div_cnt;
  logic        i_txff_empty, i_rxff_full, i_txff_rd, i_rxff_wr, i2c_done;

  int npass = 0;
  int nchk  = 0;

  always #5 clk = ~clk;

  i2c_apb_regs dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq), .i_ready(i_ready),
    .data_addr_rw(data_addr_rw), .data_cnt(data_cnt), .div_cnt(div_cnt),
    .data_in(data_in), .i_txff_empty(i_txff_empty), .i_rxff_full(i_rxff_full),
    .i_txff_rd(i_txff_rd), .i_rxff_wr(i_rxff_wr), .data_out(data_out),
    .i2c_done(i2c_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic apb_wr(input logic [4:0] ad, input logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = ad; pwdata = d; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1; #1;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [4:0] ad, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; paddr = ad; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1; #1;
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic txrd_pulse();
    @(posedge clk); #1; i_txff_rd = 1'b1;
    @(posedge clk); #1; i_txff_rd = 1'b0;
  endtask

  task automatic rxwr_pulse(input logic [7:0] d);
    @(posedge clk); #1; i_rxff_wr = 1'b1; data_out = d;
    @(posedge clk); #1; i_rxff_wr = 1'b0;
  endtask

  task automatic done_pulse();
    @(posedge clk); #1; i2c_done = 1'b1;
    @(posedge clk); #1; i2c_done = 1'b0;
  endtask

  logic        e;
  logic [31:0] r;

  initial begin
    rst = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    i_txff_rd = 0; i_rxff_wr = 0; data_out = '0; i2c_done = 0;
    repeat (3) @(posedge clk); #1;

    // reset state
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_txempty", 32'(i_txff_empty), 32'd1);
    chk("rst_rxfull",  32'(i_rxff_full), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'h0);
    chk("rst_irq",     32'(irq), 32'd0);
    chk("rst_prdata",  prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_pready",  32'(pready), 32'd1);
    rst = 1'b1;
    apb_rd(5'h18, r); chk("rst_status", r, 32'h14);

    // configure and start a transfer
    apb_wr(5'h04, 32'hA0, e);   chk("wr_addr_err", 32'(e), 0);
    apb_wr(5'h08, 32'h1, e);
    apb_wr(5'h0C, 32'h40, e);
    chk("div_out", 32'(div_cnt), 32'h40);
    apb_rd(5'h04, r); chk("rd_addr", r, 32'hA0);
    apb_wr(5'h10, 32'h11, e);
    chk("push_vis", 32'(data_in), 32'h11);
    apb_wr(5'h10, 32'h22, e);
    apb_wr(5'h00, 32'h1, e);    chk("start_err", 32'(e), 0);
    chk("start_ready", 32'(i_ready), 1);
    chk("start_din",   32'(data_in), 32'h11);
    apb_rd(5'h18, r); chk("busy_status", r, 32'h211);

    // busy protection
    apb_wr(5'h08, 32'h5, e);    chk("busy_cnt_err", 32'(e), 1);
    apb_rd(5'h08, r);           chk("busy_cnt_keep", r, 32'h1);
    apb_wr(5'h00, 32'h1, e);    chk("busy_start_err", 32'(e), 1);
    apb_wr(5'h00, 32'h100, e);  chk("busy_irqen_err", 32'(e), 0);

    // master pops one byte, then finishes
    txrd_pulse();
    chk("pop_din", 32'(data_in), 32'h22);
    apb_rd(5'h18, r); chk("pop_status", r, 32'h111);
    done_pulse();
    chk("done_ready", 32'(i_ready), 0);
    chk("done_irq",   32'(irq), 1);
    apb_rd(5'h18, r); chk("done_status", r, 32'h112);
    apb_wr(5'h18, 32'h2, e);
    chk("irq_clr", 32'(irq), 0);
    chk("no_extra_xfer", 32'(i_ready), 0);
    apb_rd(5'h00, r); chk("rd_ctrl", r, 32'h100);

    // TX overflow
    txrd_pulse();
    chk("tx_drained", 32'(i_txff_empty), 1);
    for (int i = 0; i < 9; i++) apb_wr(5'h10, 32'h30 + 32'(i), e);
    apb_rd(5'h18, r); chk("ovf_status", r, 32'h858);
    chk("ovf_head", 32'(data_in), 32'h30);
    apb_wr(5'h18, 32'h40, e);
    apb_rd(5'h18, r); chk("ovf_clr", r, 32'h818);
    apb_wr(5'h00, 32'h2, e);
    chk("txclr_empty", 32'(i_txff_empty), 1);

    // RX path and underflow
    rxwr_pulse(8'h5A);
    rxwr_pulse(8'hC3);
    apb_rd(5'h14, r); chk("rx0", r, 32'h5A);
    apb_rd(5'h14, r); chk("rx1", r, 32'hC3);
    apb_rd(5'h14, r); chk("rx_empty_rd", r, 32'h0);
    apb_rd(5'h18, r); chk("udf_status", r, 32'h94);

    // simultaneous push and pop at level 3
    apb_wr(5'h10, 32'h61, e);
    apb_wr(5'h10, 32'h62, e);
    apb_wr(5'h10, 32'h63, e);
    fork
      apb_wr(5'h10, 32'h64, e);
      begin
        repeat (2) @(posedge clk); #1; i_txff_rd = 1'b1;
        @(posedge clk); #1; i_txff_rd = 1'b0;
      end
    join
    apb_rd(5'h18, r); chk("pp_status", r, 32'h390);
    chk("pp_head0", 32'(data_in), 32'h62);
    txrd_pulse(); chk("pp_head1", 32'(data_in), 32'h63);
    txrd_pulse(); chk("pp_head2", 32'(data_in), 32'h64);

    // clear beats same-cycle pop (TX) and push (RX)
    fork
      apb_wr(5'h00, 32'h6, e);
      begin
        repeat (2) @(posedge clk); #1;
        i_txff_rd = 1'b1; i_rxff_wr = 1'b1; data_out = 8'h77;
        @(posedge clk); #1; i_txff_rd = 1'b0; i_rxff_wr = 1'b0;
      end
    join
    apb_rd(5'h18, r); chk("clr_status", r, 32'h94);
    apb_wr(5'h18, 32'h80, e);
    apb_rd(5'h18, r); chk("udf_clr", r, 32'h14);

    // asynchronous reset mid-transfer
    apb_wr(5'h10, 32'h99, e);
    apb_wr(5'h00, 32'h1, e);
    chk("xfer2_ready", 32'(i_ready), 1);
    #2 rst = 1'b0; #1;
    chk("arst_ready",  32'(i_ready), 0);
    chk("arst_txempty", 32'(i_txff_empty), 1);
    chk("arst_din",    32'(data_in), 0);
    @(posedge clk); #1 rst = 1'b1;
    apb_rd(5'h18, r); chk("arst_status", r, 32'h14);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
